contador_cronometro: RTL and testbench

- Stopwatch counting core directly downstream of the button/command stage.
- Consumes that stage's level commands (resetC, contarC, pausarC, pararC) and produces the four live BCD digits it monitors for the 9999 auto-reset.
- Also produces display digits that freeze during a lap (pausar) while counting continues.
- Contains a tick prescaler, a 4-state mode FSM and a 4-digit BCD counter chain.

---
 rtl/cronometro_pkg.sv | 14 +
 rtl/contador_cronometro_digito_bcd.sv | 26 ++
 rtl/contador_cronometro.sv | 129 ++++++++++++
 tb/tb_contador_cronometro.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch counting core.
package cronometro_pkg;

  typedef enum logic [1:0] {
    ZERADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    PARADO   = 2'd3
  } estado_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         DIGITS  = 4;

endpackage

// File: rtl/contador_cronometro_digito_bcd.sv
// One BCD decade: wraps 9 -> 0 and emits a carry on that wrap.
module digito_bcd
  import cronometro_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc && (digit == BCD_MAX);

  // Digit register: clear has priority over increment.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/contador_cronometro.sv
// Stopwatch core: tick prescaler, mode FSM, 4-digit BCD chain and lap display.
//
// state    | meaning
// ZERADO   | cleared, waiting for a run command
// CONTANDO | counting, display shows live count
// PAUSADO  | counting, display frozen on lap value
// PARADO   | counting stopped, value held
module contador_cronometro
  import cronometro_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       resetC,
  input  logic       contarC,
  input  logic       pausarC,
  input  logic       pararC,
  output logic [3:0] num_ms,
  output logic [3:0] num_cs,
  output logic [3:0] num_ds,
  output logic [3:0] num_us,
  output logic [3:0] disp_ms,
  output logic [3:0] disp_cs,
  output logic [3:0] disp_ds,
  output logic [3:0] disp_us,
  output logic [1:0] estado,
  output logic       satur
);

  localparam int PW = $clog2(DIV);

  estado_t state, state_next;
  logic    run, show_lap, tick;
  logic [PW-1:0] presc;
  logic [DIGITS-1:0][3:0] num_vec, lap_vec, disp_vec;
  logic [DIGITS:0] carry;
  logic carry_unused;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ZERADO;
    else         state <= state_next;
  end

  // Next state: highest-priority asserted command decides; ignored commands hold.
  always_comb begin
    state_next = state;
    if (resetC) begin
      state_next = ZERADO;
    end else if (pararC) begin
      if (state != ZERADO) state_next = PARADO;
    end else if (pausarC) begin
      if (state == CONTANDO) state_next = PAUSADO;
    end else if (contarC) begin
      state_next = CONTANDO;
    end
  end

  // Mode decode from the current state.
  always_comb begin
    run      = 1'b0;
    show_lap = 1'b0;
    case (state)
      CONTANDO: run = 1'b1;
      PAUSADO: begin
        run      = 1'b1;
        show_lap = 1'b1;
      end
      default: ;
    endcase
  end

  assign tick = run && (presc == PW'(DIV - 1));

  // Prescaler: free-runs while counting, holds when stopped, zero when cleared.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
    end else if (resetC || state == ZERADO) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Saturation suppresses the increment at the bottom of the chain.
  assign satur    = (num_vec == {DIGITS{BCD_MAX}});
  assign carry[0] = tick && !satur;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      digito_bcd u_dig (
        .clock     (clock),
        .resetn    (resetn),
        .clr       (resetC),
        .inc       (carry[i]),
        .digit     (num_vec[i]),
        .carry_out (carry[i+1])
      );
    end
  endgenerate

  // Saturation makes a carry out of the top decade impossible.
  assign carry_unused = carry[DIGITS];

  // Lap capture on the edge entering PAUSADO, using the pre-increment count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lap_vec <= '0;
    end else if (state == CONTANDO && state_next == PAUSADO) begin
      lap_vec <= num_vec;
    end
  end

  assign disp_vec = show_lap ? lap_vec : num_vec;

  assign num_us  = num_vec[0];
  assign num_ds  = num_vec[1];
  assign num_cs  = num_vec[2];
  assign num_ms  = num_vec[3];
  assign disp_us = disp_vec[0];
  assign disp_ds = disp_vec[1];
  assign disp_cs = disp_vec[2];
  assign disp_ms = disp_vec[3];
  assign estado  = state;

endmodule

// File: tb/tb_contador_cronometro.sv
// Directed bench for the stopwatch core with a 4-cycle prescaler.
module tb_contador_cronometro;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic resetC = 1'b0, contarC = 1'b0, pausarC = 1'b0, pararC = 1'b0;
  logic [3:0] num_ms, num_cs, num_ds, num_us;
  logic [3:0] disp_ms, disp_cs, disp_ds, disp_us;
  logic [1:0] estado;
  logic       satur;
  int errors = 0;
  int checks = 0;

  wire [15:0] num  = {num_ms, num_cs, num_ds, num_us};
  wire [15:0] disp = {disp_ms, disp_cs, disp_ds, disp_us};

  contador_cronometro #(.DIV(4)) dut (
    .clock(clock), .resetn(resetn),
    .resetC(resetC), .contarC(contarC), .pausarC(pausarC), .pararC(pararC),
    .num_ms(num_ms), .num_cs(num_cs), .num_ds(num_ds), .num_us(num_us),
    .disp_ms(disp_ms), .disp_cs(disp_cs), .disp_ds(disp_ds), .disp_us(disp_us),
    .estado(estado), .satur(satur)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_contar();
    contarC = 1'b1; cyc(1); contarC = 1'b0;
  endtask

  task automatic pulse_reset();
    resetC = 1'b1; cyc(1); resetC = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_num", num, 16'h0000);
    check("rst_disp", disp, 16'h0000);
    check("rst_estado", {14'd0, estado}, 16'd0);
    check("rst_satur", {15'd0, satur}, 16'd0);
    @(posedge clock); #1; resetn = 1'b1;
    cyc(2);
    check("idle_estado", {14'd0, estado}, 16'd0);

    // Start counting: first increment 4 cycles after entry.
    pulse_contar();
    check("run_estado", {14'd0, estado}, 16'd1);
    cyc(3);
    check("pre_first_tick", num, 16'h0000);
    cyc(1);
    check("first_tick", num, 16'h0001);
    cyc(8);
    check("count3", num, 16'h0003);
    check("disp_live", disp, 16'h0003);
    cyc(24);
    check("count9", num, 16'h0009);
    cyc(4);
    check("carry_ds", num, 16'h0010);
    cyc(989 * 4);
    check("count999", num, 16'h0999);
    cyc(4);
    check("carry_ms", num, 16'h1000);
    pulse_reset();
    check("clr_num", num, 16'h0000);
    check("clr_estado", {14'd0, estado}, 16'd0);

    // Lap: display freezes while counting continues.
    pulse_contar();
    cyc(20);
    check("lap_pre", num, 16'h0005);
    pausarC = 1'b1; cyc(1); pausarC = 1'b0;
    check("lap_estado", {14'd0, estado}, 16'd2);
    check("lap_disp0", disp, 16'h0005);
    cyc(8);
    check("lap_num", num, 16'h0007);
    check("lap_disp", disp, 16'h0005);
    pulse_contar();
    check("lap_release", disp, 16'h0007);
    check("lap_rel_estado", {14'd0, estado}, 16'd1);

    // Stop at 0042, hold, resume with preserved phase.
    pulse_reset();
    pulse_contar();
    cyc(42 * 4);
    pararC = 1'b1; cyc(1); pararC = 1'b0;
    check("stop_estado", {14'd0, estado}, 16'd3);
    check("stop_num", num, 16'h0042);
    cyc(20);
    check("stop_hold", num, 16'h0042);
    pulse_contar();
    cyc(2);
    check("resume_phase", num, 16'h0042);
    cyc(1);
    check("resume_tick", num, 16'h0043);
    cyc(3);
    pararC = 1'b1; cyc(1); pararC = 1'b0;
    check("stop_with_tick", num, 16'h0044);
    check("stop_tick_estado", {14'd0, estado}, 16'd3);
    pausarC = 1'b1; cyc(1); pausarC = 1'b0;
    check("pause_in_parado", {14'd0, estado}, 16'd3);

    // Saturation at 9999.
    pulse_reset();
    pulse_contar();
    cyc(9998 * 4);
    check("pre_sat", {num[15:1], satur}, {15'h4ccc, 1'b0});
    cyc(4);
    check("sat_num", num, 16'h9999);
    check("sat_flag", {15'd0, satur}, 16'd1);
    cyc(8);
    check("sat_hold", num, 16'h9999);
    pulse_reset();
    check("sat_clr_num", num, 16'h0000);
    check("sat_clr_estado", {14'd0, estado}, 16'd0);
    check("sat_clr_flag", {15'd0, satur}, 16'd0);

    // Priority.
    pulse_contar();
    resetC = 1'b1; contarC = 1'b1; cyc(1); resetC = 1'b0; contarC = 1'b0;
    check("prio_reset", {14'd0, estado}, 16'd0);
    pulse_contar();
    pararC = 1'b1; pausarC = 1'b1; cyc(1); pararC = 1'b0; pausarC = 1'b0;
    check("prio_parar", {14'd0, estado}, 16'd3);
    pulse_reset();
    pararC = 1'b1; cyc(1); pararC = 1'b0;
    check("parar_in_zerado", {14'd0, estado}, 16'd0);

    // Async reset mid-count.
    pulse_contar();
    cyc(10);
    check("async_pre", num, 16'h0002);
    #2 resetn = 1'b0;
    #1;
    check("async_num", num, 16'h0000);
    check("async_estado", {14'd0, estado}, 16'd0);
    check("async_disp", disp, 16'h0000);
    @(posedge clock); #1; resetn = 1'b1;
    cyc(3);
    check("async_after", {14'd0, estado}, 16'd0);
    check("async_after_num", num, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
